// File: rtl/sdrc_app_pkg.sv
// ============================================================================
// sdrc_app_pkg : shared types and widths for the application-side responder
// Revision     : 1.0
// ============================================================================
`default_nettype none

package sdrc_app_pkg;

  localparam int APP_LEN_W  = 9;
  localparam int APP_ADDR_W = 30;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACKW   = 3'd1,
    ST_ACK    = 3'd2,
    ST_WBURST = 3'd3,
    ST_RLAT   = 3'd4,
    ST_RBURST = 3'd5
  } app_resp_state_t;

endpackage

`default_nettype wire

// File: rtl/sdrc_app_bram.sv
// ============================================================================
// sdrc_app_bram : single-port RAM, byte write enables, 1-cycle sync read
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sdrc_app_bram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic            clk,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW/8-1:0] we_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // No reset: contents must survive a controller reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DW/8; i++) begin
      if (we_i[i]) begin
        mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/sdrc_app_resp.sv
// ============================================================================
// sdrc_app_resp : RAM-backed responder for the SDRAM controller app interface
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sdrc_app_resp
  import sdrc_app_pkg::*;
#(
  parameter int DW      = 32,
  parameter int AW      = 10,
  parameter int ACK_DLY = 2,
  parameter int RD_LAT  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  app_req,
  input  logic [APP_ADDR_W-1:0] app_req_addr,
  input  logic [APP_LEN_W-1:0]  app_req_len,
  input  logic                  app_req_wr_n,
  output logic                  app_req_ack,
  input  logic [DW-1:0]         app_wr_data,
  input  logic [DW/8-1:0]       app_wr_en_n,
  output logic                  app_wr_next_req,
  output logic                  app_rd_valid,
  output logic [DW-1:0]         app_rd_data,
  output logic                  sdr_core_busy_n
);

  localparam logic [3:0] ACKW_INIT = (ACK_DLY == 0) ? 4'd0 : 4'(ACK_DLY - 1);
  localparam logic [3:0] RLAT_INIT = (RD_LAT < 2)   ? 4'd0 : 4'(RD_LAT - 2);

  app_resp_state_t       state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [APP_LEN_W-1:0]  cnt_q, cnt_d;
  logic [3:0]            dly_q, dly_d;
  logic                  wr_n_q, wr_n_d;

  logic [DW/8-1:0]       ram_we;
  logic [DW-1:0]         ram_rdata;
  logic [APP_ADDR_W-AW-1:0] unused_addr_hi;

  assign unused_addr_hi = app_req_addr[APP_ADDR_W-1:AW];

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      dly_q   <= '0;
      wr_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      wr_n_q  <= wr_n_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    wr_n_d  = wr_n_q;
    unique case (state_q)
      ST_IDLE: begin
        if (app_req) begin
          addr_d  = app_req_addr[AW-1:0];
          cnt_d   = app_req_len;
          wr_n_d  = app_req_wr_n;
          dly_d   = ACKW_INIT;
          state_d = (ACK_DLY == 0) ? ST_ACK : ST_ACKW;
        end
      end
      ST_ACKW: begin
        if (!app_req) begin
          state_d = ST_IDLE;
        end else if (dly_q == 4'd0) begin
          state_d = ST_ACK;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      ST_ACK: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else if (!wr_n_q) begin
          state_d = ST_WBURST;
        end else if (RD_LAT < 2) begin
          state_d = ST_RBURST;
        end else begin
          dly_d   = RLAT_INIT;
          state_d = ST_RLAT;
        end
      end
      ST_WBURST: begin
        addr_d = addr_q + AW'(1);
        cnt_d  = cnt_q - APP_LEN_W'(1);
        if (cnt_q == APP_LEN_W'(1)) state_d = ST_IDLE;
      end
      ST_RLAT: begin
        if (dly_q == 4'd0) begin
          state_d = ST_RBURST;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      ST_RBURST: begin
        cnt_d = cnt_q - APP_LEN_W'(1);
        if (cnt_q == APP_LEN_W'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // The RAM read issued on an edge lands in the following cycle, so the
    // address advances on every edge that leads into a read beat.
    if (state_d == ST_RBURST) addr_d = addr_q + AW'(1);
  end

  // Outputs
  always_comb begin
    app_req_ack     = (state_q == ST_ACK);
    app_wr_next_req = (state_q == ST_WBURST);
    app_rd_valid    = (state_q == ST_RBURST);
    app_rd_data     = (state_q == ST_RBURST) ? ram_rdata : '0;
    sdr_core_busy_n = (state_q == ST_IDLE);
    ram_we          = (state_q == ST_WBURST) ? ~app_wr_en_n : '0;
  end

  sdrc_app_bram #(
    .DW (DW),
    .AW (AW)
  ) u_bram (
    .clk     (clk),
    .addr_i  (addr_q),
    .we_i    (ram_we),
    .wdata_i (app_wr_data),
    .rdata_o (ram_rdata)
  );

endmodule

`default_nettype wire

// File: tb/tb_sdrc_app_resp.sv
// ============================================================================
// tb_sdrc_app_resp : directed vector bench for sdrc_app_resp
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_sdrc_app_resp;

  localparam int DW      = 32;
  localparam int AW      = 10;
  localparam int ACK_DLY = 2;
  localparam int RD_LAT  = 3;
  localparam int NVEC    = 11;

  typedef struct packed {
    logic             wr_n;
    logic [29:0]      addr;
    logic [8:0]       len;
    logic [3:0]       en_n;
    logic [4:0][31:0] data;   // write data, or expected read data
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        app_req;
  logic [29:0] app_req_addr;
  logic [8:0]  app_req_len;
  logic        app_req_wr_n;
  logic        app_req_ack;
  logic [31:0] app_wr_data;
  logic [3:0]  app_wr_en_n;
  logic        app_wr_next_req;
  logic        app_rd_valid;
  logic [31:0] app_rd_data;
  logic        sdr_core_busy_n;

  int checks = 0;
  int fails  = 0;
  vec_t vecs [NVEC];

  always #5 clk = ~clk;

  sdrc_app_resp #(
    .DW (DW), .AW (AW), .ACK_DLY (ACK_DLY), .RD_LAT (RD_LAT)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .app_req         (app_req),
    .app_req_addr    (app_req_addr),
    .app_req_len     (app_req_len),
    .app_req_wr_n    (app_req_wr_n),
    .app_req_ack     (app_req_ack),
    .app_wr_data     (app_wr_data),
    .app_wr_en_n     (app_wr_en_n),
    .app_wr_next_req (app_wr_next_req),
    .app_rd_valid    (app_rd_valid),
    .app_rd_data     (app_rd_data),
    .sdr_core_busy_n (sdr_core_busy_n)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic wr_n, input logic [29:0] addr, input logic [8:0] len,
                              input logic [3:0] en_n, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3, input logic [31:0] d4);
    vec_t v;
    v.wr_n = wr_n; v.addr = addr; v.len = len; v.en_n = en_n;
    v.data = {d4, d3, d2, d1, d0};
    return v;
  endfunction

  // Issue one request and follow it to completion; returns with the
  // responder back in IDLE (one cycle after the last beat).
  task automatic run_txn(input vec_t v);
    int k;
    @(posedge clk); #1;
    app_req = 1'b1; app_req_addr = v.addr; app_req_len = v.len; app_req_wr_n = v.wr_n;
    @(posedge clk); #1;
    k = 1;
    while (app_req_ack !== 1'b1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    app_req = 1'b0;
    app_req_addr = 30'h3FFF_FFFF; app_req_len = 9'h1FF; app_req_wr_n = ~v.wr_n;
    chk("ack_latency", 64'(k), 64'(ACK_DLY + 1));
    if (k >= 20) return;
    chk("busy_n_during_ack", 64'(sdr_core_busy_n), 64'd0);
    if (v.len == 9'd0) begin
      @(posedge clk); #1;
      chk("len0_after_ack", {61'd0, app_req_ack, app_wr_next_req, app_rd_valid}, 64'd0);
      chk("len0_busy_n", 64'(sdr_core_busy_n), 64'd1);
      @(posedge clk); #1;
      chk("len0_quiet", {61'd0, app_req_ack, app_wr_next_req, app_rd_valid}, 64'd0);
    end else if (!v.wr_n) begin
      for (int i = 0; i < int'(v.len); i++) begin
        @(posedge clk); #1;
        chk("wr_next_req_beat", 64'(app_wr_next_req), 64'd1);
        app_wr_data = v.data[i];
        app_wr_en_n = v.en_n;
      end
      @(posedge clk); #1;
      app_wr_data = 32'hDEAD_BEEF;
      app_wr_en_n = 4'h0;
      chk("wr_end_next_req_busy_n", {62'd0, app_wr_next_req, sdr_core_busy_n}, 64'd1);
    end else begin
      for (int j = 1; j < RD_LAT; j++) begin
        @(posedge clk); #1;
        chk("rd_latency_idle", 64'(app_rd_valid), 64'd0);
      end
      for (int i = 0; i < int'(v.len); i++) begin
        @(posedge clk); #1;
        chk("rd_valid_beat", 64'(app_rd_valid), 64'd1);
        chk("rd_data_beat", 64'(app_rd_data), 64'(v.data[i]));
      end
      @(posedge clk); #1;
      chk("rd_end_valid_busy_n", {62'd0, app_rd_valid, sdr_core_busy_n}, 64'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen;

    vecs[0]  = mk(1'b0, 30'h10000, 9'd5, 4'h0, 32'h11223344, 32'h22334455, 32'h33445566, 32'h44556677, 32'h55667788);
    vecs[1]  = mk(1'b1, 30'h10000, 9'd5, 4'h0, 32'h11223344, 32'h22334455, 32'h33445566, 32'h44556677, 32'h55667788);
    vecs[2]  = mk(1'b0, 30'h00020, 9'd1, 4'h0, 32'h11223344, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[3]  = mk(1'b0, 30'h00020, 9'd1, 4'b1010, 32'hAABBCCDD, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[4]  = mk(1'b1, 30'h00020, 9'd1, 4'h0, 32'h11BB33DD, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[5]  = mk(1'b0, 30'h003FE, 9'd4, 4'h0, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'h0);
    vecs[6]  = mk(1'b1, 30'h003FE, 9'd4, 4'h0, 32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004, 32'h0);
    vecs[7]  = mk(1'b1, 30'h00000, 9'd3, 4'h0, 32'hA0000003, 32'hA0000004, 32'h33445566, 32'h0, 32'h0);
    vecs[8]  = mk(1'b0, 30'h00040, 9'd0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[9]  = mk(1'b1, 30'h00040, 9'd0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[10] = mk(1'b1, 30'h00021, 9'd1, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    // Word 0x21 was never written; replace that row with a read of 0x3FF.
    vecs[10] = mk(1'b1, 30'h003FF, 9'd2, 4'h0, 32'hA0000002, 32'hA0000003, 32'h0, 32'h0, 32'h0);

    reset_n = 1'b0; app_req = 1'b0; app_req_addr = '0; app_req_len = '0; app_req_wr_n = 1'b1;
    app_wr_data = '0; app_wr_en_n = '1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {28'd0, app_req_ack, app_wr_next_req, app_rd_valid, sdr_core_busy_n, app_rd_data},
        {28'd0, 4'b0001, 32'h0});
    reset_n = 1'b1;

    for (int n = 0; n < NVEC; n++) run_txn(vecs[n]);

    // Request withdrawn after one cycle of the ack wait.
    @(posedge clk); #1;
    app_req = 1'b1; app_req_addr = 30'h100; app_req_len = 9'd3; app_req_wr_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_busy_in_ackw", 64'(sdr_core_busy_n), 64'd0);
    app_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      seen = seen | app_req_ack | app_wr_next_req;
    end
    chk("abort_no_ack", 64'(seen), 64'd0);
    chk("abort_back_idle", 64'(sdr_core_busy_n), 64'd1);
    run_txn(vecs[4]);

    // Reset pulse during beat 3 of a 5-beat read from word 2.
    @(posedge clk); #1;
    app_req = 1'b1; app_req_addr = 30'h10002; app_req_len = 9'd5; app_req_wr_n = 1'b1;
    repeat (ACK_DLY + 1) @(posedge clk);
    #1;
    chk("rst_seq_ack", 64'(app_req_ack), 64'd1);
    app_req = 1'b0;
    repeat (RD_LAT) @(posedge clk);
    #1;
    chk("rst_seq_beat0", {31'd0, app_rd_valid, app_rd_data}, {31'd0, 1'b1, 32'h33445566});
    @(posedge clk); #1;
    chk("rst_seq_beat1", {31'd0, app_rd_valid, app_rd_data}, {31'd0, 1'b1, 32'h44556677});
    @(posedge clk); #1;
    chk("rst_seq_beat2", {31'd0, app_rd_valid, app_rd_data}, {31'd0, 1'b1, 32'h55667788});
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    chk("rst_mid_outputs", {28'd0, app_req_ack, app_wr_next_req, app_rd_valid, sdr_core_busy_n, app_rd_data},
        {28'd0, 4'b0001, 32'h0});
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      seen = seen | app_rd_valid | app_req_ack;
    end
    chk("rst_mid_quiet", 64'(seen), 64'd0);
    run_txn(mk(1'b1, 30'h10000, 9'd5, 4'h0, 32'hA0000003, 32'hA0000004, 32'h33445566, 32'h44556677, 32'h55667788));

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

`default_nettype wire
